// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU BIST: ALU opcodes, BIST controller state
// encoding and the LFSR polynomial/step function used for random operands.
package alu_defs_pkg;

    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1 (taps 32,22,2,1 -> bits 31,21,1,0)
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference ALU used by the BIST to predict Output/Z/V/Cout.
// chk_vc flags the ops (ADD/SUB) for which V and Cout carry meaning.
module alu_golden_model
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] exp_result,
    output logic             exp_z,
    output logic             exp_v,
    output logic             exp_cout,
    output logic             chk_vc
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // SUB is I1 + ~I2 + 1, so add and subtract share one adder
    always_comb begin
        b_eff      = (op == ALUOP_SUB) ? ~i2 : i2;
        sum        = {1'b0, i1} + {1'b0, b_eff} + (WIDTH+1)'(op == ALUOP_SUB);
        exp_result = '0;
        chk_vc     = 1'b0;
        case (op)
            ALUOP_AND: exp_result = i1 & i2;
            ALUOP_OR:  exp_result = i1 | i2;
            ALUOP_ADD: begin
                exp_result = sum[WIDTH-1:0];
                chk_vc     = 1'b1;
            end
            ALUOP_SUB: begin
                exp_result = sum[WIDTH-1:0];
                chk_vc     = 1'b1;
            end
            ALUOP_SLT: exp_result = WIDTH'($signed(i1) < $signed(i2));
            default:   exp_result = '0;
        endcase
        exp_z    = (exp_result == '0);
        exp_v    = (i1[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != i1[WIDTH-1]);
        exp_cout = sum[WIDTH];
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// BIST initiator for the 32-bit ALU: applies corner then LFSR vectors, checks
// each response against alu_golden_model and reports pass/err_count/first_fail_idx.
module alu_bist_ctrl
    import alu_defs_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] SEED_A        = 32'hACE1_2B3F,
    parameter logic [31:0] SEED_B        = 32'h1D87_2C45
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] alu_i1,
    output logic [WIDTH-1:0] alu_i2,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_cout,
    output bist_state_e      dbg_state
);

    // Handshake: start is a level request sampled only in IDLE; done is a
    // one-cycle pulse and the result outputs hold until the next accepted start.
    bist_state_e state, state_nxt;
    logic [15:0] idx, ld_idx, settle_cnt;
    logic [2:0]  op_phase, ld_phase, ld_op;
    logic [31:0] lfsr_a, lfsr_b, ld_lfsr_a, ld_lfsr_b;
    logic [WIDTH-1:0] ld_i1, ld_i2;
    logic        load_first, load_next, mismatch;
    logic [WIDTH-1:0] exp_result;
    logic        exp_z, exp_v, exp_cout, chk_vc;

    alu_golden_model #(.WIDTH(WIDTH)) u_golden (
        .i1(alu_i1), .i2(alu_i2), .op(alu_op),
        .exp_result(exp_result), .exp_z(exp_z), .exp_v(exp_v),
        .exp_cout(exp_cout), .chk_vc(chk_vc)
    );

    assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);
    assign dbg_state = state;
    assign mismatch  = (alu_result != exp_result) || (alu_z != exp_z) ||
                       (chk_vc && ((alu_v != exp_v) || (alu_cout != exp_cout)));

    always_comb begin
        state_nxt  = state;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nxt  = ST_SETTLE;
                load_first = 1'b1;
            end
            ST_SETTLE: if (settle_cnt == 16'd0) state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (idx == 16'(NUM_VECTORS - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_SETTLE;
                    load_next = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Vector being loaded: vector 0 from fresh seeds, otherwise idx+1
    always_comb begin
        ld_idx    = load_first ? 16'd0 : idx + 16'd1;
        ld_phase  = (load_first || op_phase == 3'd4) ? 3'd0 : op_phase + 3'd1;
        ld_lfsr_a = load_first ? SEED_A : lfsr_a;
        ld_lfsr_b = load_first ? SEED_B : lfsr_b;
        case (ld_phase)
            3'd0:    ld_op = ALUOP_AND;
            3'd1:    ld_op = ALUOP_OR;
            3'd2:    ld_op = ALUOP_ADD;
            3'd3:    ld_op = ALUOP_SUB;
            default: ld_op = ALUOP_SLT;
        endcase
        ld_i1 = WIDTH'(ld_lfsr_a);
        ld_i2 = WIDTH'(ld_lfsr_b);
        if (ld_idx < 16'd5) begin
            case (ld_idx[2:0])
                3'd0: begin ld_i1 = '0;                          ld_i2 = '0; end
                3'd1: begin ld_i1 = '1;                          ld_i2 = '0; end
                3'd2: begin ld_i1 = {1'b0, {(WIDTH-1){1'b1}}};   ld_i2 = WIDTH'(1); end
                3'd3: begin ld_i1 = '0;                          ld_i2 = WIDTH'(1); end
                default: begin ld_i1 = {1'b1, {(WIDTH-1){1'b0}}}; ld_i2 = WIDTH'(1); end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 16'd0;
            first_fail_idx <= 16'hFFFF;
            alu_i1         <= '0;
            alu_i2         <= '0;
            alu_op         <= ALUOP_AND;
            idx            <= 16'd0;
            op_phase       <= 3'd0;
            settle_cnt     <= 16'd0;
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (load_first || load_next) begin
                alu_i1     <= ld_i1;
                alu_i2     <= ld_i2;
                alu_op     <= ld_op;
                idx        <= ld_idx;
                op_phase   <= ld_phase;
                lfsr_a     <= lfsr_step(ld_lfsr_a);
                lfsr_b     <= lfsr_step(ld_lfsr_b);
                settle_cnt <= 16'(SETTLE_CYCLES - 1);
            end else if (state == ST_SETTLE && settle_cnt != 16'd0) begin
                settle_cnt <= settle_cnt - 16'd1;
            end
            if (load_first) begin
                err_count      <= 16'd0;
                first_fail_idx <= 16'hFFFF;
                pass           <= 1'b0;
            end
            // err_count only leaves zero on the first mismatch of a run
            if (state == ST_CHECK && mismatch) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (err_count == 16'd0)    first_fail_idx <= idx;
            end
            if (state == ST_DONE) begin
                done <= 1'b1;
                pass <= (err_count == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl with a behavioural ALU attached that can
// have its V or Z flag stuck at 0.
module tb_alu_bist_ctrl;
    import alu_defs_pkg::*;

    localparam int NV = 16;
    localparam int SC = 2;
    localparam logic [31:0] SA = 32'hACE1_2B3F;
    localparam logic [31:0] SB = 32'h1D87_2C45;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count, first_fail_idx;
    logic [31:0] alu_i1, alu_i2, alu_result;
    logic [2:0]  alu_op;
    logic        alu_z, alu_v, alu_cout;
    bist_state_e dbg_state;
    logic        fault_v = 1'b0;
    logic        fault_z = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    alu_bist_ctrl #(.WIDTH(32), .NUM_VECTORS(NV), .SETTLE_CYCLES(SC),
                    .SEED_A(SA), .SEED_B(SB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_fail_idx(first_fail_idx),
        .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_z(alu_z), .alu_v(alu_v),
        .alu_cout(alu_cout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // returns {cout, v, z, result}
    function automatic logic [34:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] r;
        logic [32:0] s;
        logic v, c;
        r = 32'h0; v = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
        return {c, v, (r == 32'h0), r};
    endfunction

    function automatic logic [31:0] step32(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s = s >> 1;
        if (fb) s = s ^ 32'h8020_0003;
        return s;
    endfunction

    function automatic void gen_vec(input int k, output logic [31:0] a,
                                    output logic [31:0] b, output logic [2:0] op);
        logic [2:0] ops [5];
        logic [31:0] ca [5];
        logic [31:0] cb [5];
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        ca  = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
        cb  = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h1};
        op = ops[k % 5];
        if (k < 5) begin
            a = ca[k]; b = cb[k];
        end else begin
            a = SA; b = SB;
            for (int j = 0; j < k; j++) begin
                a = step32(a); b = step32(b);
            end
        end
    endfunction

    // mode 1: V stuck at 0, mode 2: Z stuck at 0
    function automatic int count_errs(input int mode);
        logic [31:0] a, b;
        logic [2:0] op;
        logic [34:0] r;
        int cnt;
        cnt = 0;
        for (int k = 0; k < NV; k++) begin
            gen_vec(k, a, b, op);
            r = ref_alu(a, b, op);
            if (mode == 1 && (op == 3'b010 || op == 3'b110) && r[33]) cnt++;
            if (mode == 2 && r[32]) cnt++;
        end
        return cnt;
    endfunction

    always_comb begin
        logic [34:0] r;
        r = ref_alu(alu_i1, alu_i2, alu_op);
        alu_result = r[31:0];
        alu_z      = fault_z ? 1'b0 : r[32];
        alu_v      = fault_v ? 1'b0 : r[33];
        alu_cout   = r[34];
    end

    // Called #1 after a posedge; returns #1 after the edge that sampled start
    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit got);
        cyc = 0; got = 1'b0;
        while (cyc < 400 && !got) begin
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy=%b done=%b pass=%b state=%0d, need 0 0 0 0",
                     busy, done, pass, dbg_state);
        end
        n_checks++;
        if (err_count !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_results: err=%h ffi=%h, need 0000 ffff", err_count, first_fail_idx);
        end
        n_checks++;
        if (alu_i1 !== 32'h0 || alu_i2 !== 32'h0 || alu_op !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_alu: %h %h %b, need 0 0 000", alu_i1, alu_i2, alu_op);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_run();
        int cyc; bit got;
        start_run();
        wait_done(cyc, got);
        n_checks++;
        if (!got || cyc != 49) begin
            n_fail++;
            $display("FAIL clean_latency: got=%0b cycles=%0d, need done after 49", got, cyc);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL clean_result: pass=%b err=%h ffi=%h, need 1 0000 ffff",
                     pass, err_count, first_fail_idx);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_pulse: done=%b busy=%b one cycle later, need 0 0", done, busy);
        end
    endtask

    task automatic test_corner_vectors();
        int cyc; bit got;
        start_run();
        n_checks++;
        if (alu_i1 !== 32'h0 || alu_i2 !== 32'h0 || alu_op !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL vec0: %h %h %b busy=%b, need 0 0 000 1", alu_i1, alu_i2, alu_op, busy);
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 9) begin
                n_checks++;
                if (alu_i1 !== 32'h0 || alu_i2 !== 32'h1 || alu_op !== 3'b110) begin
                    n_fail++;
                    $display("FAIL vec3: %h %h %b, need 00000000 00000001 110", alu_i1, alu_i2, alu_op);
                end
                n_checks++;
                if (dut.u_golden.exp_result !== 32'hFFFF_FFFF || dut.u_golden.exp_v !== 1'b0 ||
                    dut.u_golden.exp_cout !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vec3_golden: %h v=%b c=%b, need ffffffff 0 0",
                             dut.u_golden.exp_result, dut.u_golden.exp_v, dut.u_golden.exp_cout);
                end
            end
            if (c == 12) begin
                n_checks++;
                if (alu_i1 !== 32'h8000_0000 || alu_i2 !== 32'h1 || alu_op !== 3'b111) begin
                    n_fail++;
                    $display("FAIL vec4: %h %h %b, need 80000000 00000001 111", alu_i1, alu_i2, alu_op);
                end
            end
        end
        wait_done(cyc, got);
        n_checks++;
        if (!got || cyc != 37 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_run_end: got=%0b cycles=%0d pass=%b, need 1 37 1", got, cyc, pass);
        end
    endtask

    task automatic test_v_fault();
        int cyc; bit got; int exp_err;
        exp_err = count_errs(1);
        fault_v = 1'b1;
        start_run();
        wait_done(cyc, got);
        fault_v = 1'b0;
        n_checks++;
        if (!got || first_fail_idx !== 16'd2 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL vfault_first: got=%0b ffi=%0d pass=%b, need 1 2 0", got, first_fail_idx, pass);
        end
        n_checks++;
        if (err_count < 16'd1 || err_count != 16'(exp_err)) begin
            n_fail++;
            $display("FAIL vfault_count: err=%0d, need %0d", err_count, exp_err);
        end
    endtask

    task automatic test_z_fault();
        int cyc; bit got; int exp_err;
        exp_err = count_errs(2);
        fault_z = 1'b1;
        start_run();
        wait_done(cyc, got);
        fault_z = 1'b0;
        n_checks++;
        if (!got || first_fail_idx !== 16'd0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL zfault_first: got=%0b ffi=%0d pass=%b, need 1 0 0", got, first_fail_idx, pass);
        end
        n_checks++;
        if (err_count != 16'(exp_err)) begin
            n_fail++;
            $display("FAIL zfault_count: err=%0d, need %0d", err_count, exp_err);
        end
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (err_count != 16'(exp_err) || first_fail_idx !== 16'd0) begin
            n_fail++;
            $display("FAIL results_hold: err=%0d ffi=%0d, need %0d 0", err_count, first_fail_idx, exp_err);
        end
    endtask

    task automatic test_reset_abort();
        int cyc; bit got; int dones;
        logic [31:0] v5_a, v5_b, ea, eb;
        logic [2:0] eop;
        gen_vec(5, ea, eb, eop);
        start_run();
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            if (c == 15) begin
                v5_a = alu_i1; v5_b = alu_i2;
                n_checks++;
                if (alu_i1 !== ea || alu_i2 !== eb || alu_op !== eop) begin
                    n_fail++;
                    $display("FAIL vec5: %h %h %b, need %h %h %b", alu_i1, alu_i2, alu_op, ea, eb, eop);
                end
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0 || done !== 1'b0 || alu_i1 !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_state: state=%0d busy=%b done=%b i1=%h, need 0 0 0 0",
                     dbg_state, busy, done, alu_i1);
        end
        dones = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d active cycles after reset, need 0", dones);
        end
        start_run();
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (alu_i1 !== v5_a || alu_i2 !== v5_b) begin
            n_fail++;
            $display("FAIL reseed: vec5 %h %h, need %h %h", alu_i1, alu_i2, v5_a, v5_b);
        end
        wait_done(cyc, got);
        n_checks++;
        if (!got || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_pass: got=%0b pass=%b, need 1 1", got, pass);
        end
    endtask

    task automatic test_start_held();
        int cyc; int dones; int busy_cycles; bit dropped;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; dones = 0; dropped = 1'b0;
        while (cyc < 400 && !dropped) begin
            @(posedge clk); #1;
            cyc++;
            if (done) dones++;
            if (!busy) dropped = 1'b1;
        end
        n_checks++;
        if (!dropped || cyc != 48 || dbg_state !== ST_DONE) begin
            n_fail++;
            $display("FAIL held_busy: dropped=%0b cycles=%0d state=%0d, need 1 48 3", dropped, cyc, dbg_state);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (done) dones++;
        busy_cycles = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) busy_cycles++;
        end
        n_checks++;
        if (dones != 1 || busy_cycles != 0) begin
            n_fail++;
            $display("FAIL held_single_run: dones=%0d busy_cycles=%0d, need 1 0", dones, busy_cycles);
        end
        start_run();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_start: busy=%b, need 1", busy);
        end
        wait_done(cyc, dropped);
        n_checks++;
        if (!dropped || cyc != 49) begin
            n_fail++;
            $display("FAIL back_to_back: got=%0b cycles=%0d, need 1 49", dropped, cyc);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_clean_run();
        test_corner_vectors();
        test_v_fault();
        test_z_fault();
        test_reset_abort();
        test_start_held();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
